// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg : definitions shared by the ARMv8 5-stage core front-end blocks
//           (pipe_hazard_ctrl and the ID-stage control decoder cpu_cntrl).
//
// Contents:
//   hazard_state_t  - sequencing FSM state {IDLE, MUL_BUSY}
//   XZR             - register number of the zero register; never hazards
//   REG_W           - register-specifier field width
//   OPCODE_W        - widest opcode field (R/D-format) shared with cpu_cntrl
//   MUL_CNT_W       - width of the MUL occupancy down-counter
//   src_hits_dst()  - "does this source operand read the EX destination"
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int REG_W     = 5;
  localparam int OPCODE_W  = 11;
  localparam int CB_OP_W   = 8;
  localparam int B_OP_W    = 6;
  localparam int MUL_CNT_W = 4;

  localparam logic [REG_W-1:0] XZR = 5'd31;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } hazard_state_t;

  // True when a used source register matches a real (non-XZR) destination.
  function automatic logic src_hits_dst(input logic             uses,
                                        input logic [REG_W-1:0] src,
                                        input logic [REG_W-1:0] dst);
    return uses && (src == dst) && (dst != XZR);
  endfunction

endpackage : cpu_pkg

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if : signal bundle between the pipeline datapath and the
// hazard/sequencing controller.
//
// Handshake: mul_start is a single-cycle strobe meaning "the MUL in ID moves
// into EX on this edge"; mul_busy stays high for every following cycle the
// MUL occupies EX. There is no back-pressure on mul_start: the MUL unit must
// accept it whenever it is asserted.
//
// Modports:
//   master : pipeline side - drives decoded ID/EX fields, receives controls
//   slave  : controller side (pipe_hazard_ctrl)
//
// Debug: dbg_state / dbg_mul_cnt expose the controller's registered state.
// Parameter CNT_W: width of the performance counter outputs.
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  import cpu_pkg::*;

  // ID stage
  logic             id_valid;
  logic [REG_W-1:0] id_rn;
  logic [REG_W-1:0] id_rm;
  logic             id_uses_rn;
  logic             id_uses_rm;
  logic             id_is_mul;
  logic             id_is_blt;
  // EX stage
  logic             ex_valid;
  logic [REG_W-1:0] ex_rd;
  logic             ex_mem_read;
  logic             ex_set_flags;
  logic             br_taken;
  // controls
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             mul_start;
  logic             mul_busy;
  // performance counters
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  // debug
  hazard_state_t    dbg_state;
  logic [MUL_CNT_W-1:0] dbg_mul_cnt;

  modport master (
    output id_valid, id_rn, id_rm, id_uses_rn, id_uses_rm, id_is_mul,
           id_is_blt, ex_valid, ex_rd, ex_mem_read, ex_set_flags, br_taken,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, mul_start, mul_busy,
           stall_cycles, flush_count, dbg_state, dbg_mul_cnt
  );

  modport slave (
    input  id_valid, id_rn, id_rm, id_uses_rn, id_uses_rm, id_is_mul,
           id_is_blt, ex_valid, ex_rd, ex_mem_read, ex_set_flags, br_taken,
    output pc_en, ifid_en, ifid_flush, idex_bubble, mul_start, mul_busy,
           stall_cycles, flush_count, dbg_state, dbg_mul_cnt
  );

endinterface : pipe_hazard_ctrl_if

// File: rtl/pipe_hazard_ctrl_perf_cnt.sv
// ---------------------------------------------------------------------------
// hazard_perf_cnt : saturating event counter.
//
// Ports:
//   clk      - core clock, rising edge
//   reset    - asynchronous reset, active-low; clears the count
//   i_inc    - count one event this cycle
//   o_count  - current count; holds at all-ones once reached
// Parameter W: counter width.
// ---------------------------------------------------------------------------
module hazard_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule : hazard_perf_cnt

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl : pipeline sequencing controller for the 5-stage ARMv8
// core. Looks at decoded ID-stage fields and EX-stage state and produces the
// PC / IF-ID enables, the IF-ID flush and the ID-EX bubble. Covers load-use,
// flag-use (B.LT behind ADDS/SUBS) and taken-branch hazards, and sequences
// the multi-cycle MUL unit with a start strobe and a busy level.
//
// Ports:
//   clk    - core clock, rising edge
//   reset  - asynchronous reset, active-low
//   bus    - pipe_hazard_ctrl_if.slave (ID/EX inputs, control outputs,
//            optional performance counters, debug state)
//
// Parameters:
//   MUL_LAT - EX-stage cycles one MUL occupies (1..15)
//   CNT_W   - performance counter width
//
// Build option: define HAZARD_PERF_CNT_EN to build the stall_cycles and
// flush_count counters; otherwise both outputs read as zero.
//
// Priority each cycle (highest first): taken branch flush (IDLE only),
// MUL occupancy stall, load-use / flag-use stall, MUL issue, normal flow.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  bus
);

  // A MUL that fits in one cycle never enters MUL_BUSY.
  localparam logic                 L_MUL_MULTI = (MUL_LAT > 1);
  localparam logic [MUL_CNT_W-1:0] L_MUL_LOAD  = MUL_CNT_W'(MUL_LAT - 1);

  hazard_state_t        r_state;
  hazard_state_t        w_state_nxt;
  logic [MUL_CNT_W-1:0] r_mul_cnt;
  logic [MUL_CNT_W-1:0] w_mul_cnt_nxt;

  logic w_load_use;
  logic w_flag_use;
  logic w_pc_en;
  logic w_ifid_en;
  logic w_ifid_flush;
  logic w_idex_bubble;
  logic w_mul_start;
  logic w_mul_busy;

  // -------------------------------------------------------------------------
  // Hazard detection
  // -------------------------------------------------------------------------
  assign w_load_use = bus.ex_valid && bus.ex_mem_read &&
                      (src_hits_dst(bus.id_uses_rn, bus.id_rn, bus.ex_rd) ||
                       src_hits_dst(bus.id_uses_rm, bus.id_rm, bus.ex_rd));

  assign w_flag_use = bus.id_valid && bus.id_is_blt &&
                      bus.ex_valid && bus.ex_set_flags;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_mul_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_mul_cnt <= w_mul_cnt_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and controls
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_mul_cnt_nxt = r_mul_cnt;
    w_pc_en       = 1'b1;
    w_ifid_en     = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_mul_start   = 1'b0;
    w_mul_busy    = 1'b0;

    // While reset is held the controls sit at their free-running values,
    // regardless of whatever the (also resetting) pipeline presents.
    if (reset) begin
      unique case (r_state)
        IDLE: begin
          if (bus.br_taken) begin
            // ID holds a wrong-path instruction: kill it, no other hazard
            // or MUL issue applies to it.
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
          end else if (w_load_use || w_flag_use) begin
            // One bubble is enough: next cycle EX holds the NOP, so the
            // hazard term clears by itself.
            w_pc_en       = 1'b0;
            w_ifid_en     = 1'b0;
            w_idex_bubble = 1'b1;
          end else if (bus.id_valid && bus.id_is_mul) begin
            w_mul_start = 1'b1;
            if (L_MUL_MULTI) begin
              w_state_nxt   = MUL_BUSY;
              w_mul_cnt_nxt = L_MUL_LOAD;
            end
          end
        end

        MUL_BUSY: begin
          // EX is owned by the MUL. A taken branch cannot legally appear
          // here (it would be younger than the MUL), so br_taken is ignored.
          w_pc_en       = 1'b0;
          w_ifid_en     = 1'b0;
          w_mul_busy    = 1'b1;
          w_mul_cnt_nxt = r_mul_cnt - MUL_CNT_W'(1);
          // <= 1 rather than == 1 so a corrupted zero count cannot wedge.
          if (r_mul_cnt <= MUL_CNT_W'(1)) begin
            w_state_nxt = IDLE;
          end
        end

        default: begin
          w_state_nxt   = IDLE;
          w_mul_cnt_nxt = '0;
        end
      endcase
    end
  end

  assign bus.pc_en       = w_pc_en;
  assign bus.ifid_en     = w_ifid_en;
  assign bus.ifid_flush  = w_ifid_flush;
  assign bus.idex_bubble = w_idex_bubble;
  assign bus.mul_start   = w_mul_start;
  assign bus.mul_busy    = w_mul_busy;
  assign bus.dbg_state   = r_state;
  assign bus.dbg_mul_cnt = r_mul_cnt;

  // -------------------------------------------------------------------------
  // Performance counters
  // -------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (~w_pc_en),
    .o_count (bus.stall_cycles)
  );

  hazard_perf_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_ifid_flush),
    .o_count (bus.flush_count)
  );
`else
  assign bus.stall_cycles = '0;
  assign bus.flush_count  = '0;
`endif

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl : self-checking bench for pipe_hazard_ctrl.
// dut  : MUL_LAT=3 (main instance)
// dut1 : MUL_LAT=1 (single-cycle MUL sequencing)
// Both instances see identical stimulus; each scenario checks one of them.
// Output vector order: {pc_en, ifid_en, ifid_flush, idex_bubble,
//                       mul_start, mul_busy}
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
  import cpu_pkg::*;

  localparam int CNT_W = 32;

  localparam logic [5:0] E_RUN   = 6'b110000;
  localparam logic [5:0] E_STALL = 6'b000100;
  localparam logic [5:0] E_FLUSH = 6'b111100;
  localparam logic [5:0] E_START = 6'b110010;
  localparam logic [5:0] E_BUSY  = 6'b000001;

  typedef struct packed {
    logic       id_valid;
    logic [4:0] id_rn;
    logic [4:0] id_rm;
    logic       uses_rn;
    logic       uses_rm;
    logic       is_mul;
    logic       is_blt;
    logic       ex_valid;
    logic [4:0] ex_rd;
    logic       mem_read;
    logic       set_flags;
    logic       br_taken;
    logic [5:0] exp;
  } vec_t;

  logic clk;
  logic reset;

  int n_checks;
  int n_fail;
  int exp_stall;
  int exp_flush;

  logic [5:0] exp_q[$];
  logic [5:0] got;
  logic [5:0] e;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus  ();
  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus1 ();

  pipe_hazard_ctrl #(.MUL_LAT(3), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  pipe_hazard_ctrl #(.MUL_LAT(1), .CNT_W(CNT_W)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver ----------------
  function automatic vec_t mk(input logic idv, input logic [4:0] rn,
                              input logic [4:0] rm, input logic urn,
                              input logic urm, input logic mul,
                              input logic blt, input logic exv,
                              input logic [4:0] exrd, input logic mr,
                              input logic sf, input logic br,
                              input logic [5:0] ex);
    vec_t v;
    v.id_valid = idv;  v.id_rn = rn;     v.id_rm = rm;
    v.uses_rn = urn;   v.uses_rm = urm;  v.is_mul = mul;
    v.is_blt = blt;    v.ex_valid = exv; v.ex_rd = exrd;
    v.mem_read = mr;   v.set_flags = sf; v.br_taken = br;
    v.exp = ex;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.id_valid      = v.id_valid;  bus1.id_valid     = v.id_valid;
    bus.id_rn         = v.id_rn;     bus1.id_rn        = v.id_rn;
    bus.id_rm         = v.id_rm;     bus1.id_rm        = v.id_rm;
    bus.id_uses_rn    = v.uses_rn;   bus1.id_uses_rn   = v.uses_rn;
    bus.id_uses_rm    = v.uses_rm;   bus1.id_uses_rm   = v.uses_rm;
    bus.id_is_mul     = v.is_mul;    bus1.id_is_mul    = v.is_mul;
    bus.id_is_blt     = v.is_blt;    bus1.id_is_blt    = v.is_blt;
    bus.ex_valid      = v.ex_valid;  bus1.ex_valid     = v.ex_valid;
    bus.ex_rd         = v.ex_rd;     bus1.ex_rd        = v.ex_rd;
    bus.ex_mem_read   = v.mem_read;  bus1.ex_mem_read  = v.mem_read;
    bus.ex_set_flags  = v.set_flags; bus1.ex_set_flags = v.set_flags;
    bus.br_taken      = v.br_taken;  bus1.br_taken     = v.br_taken;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    // Hazardous inputs while reset is held must not leak to the outputs.
    drive(mk(1, 2, 2, 1, 1, 1, 1, 1, 2, 1, 1, 1, E_RUN));
    exp_q.push_back(E_RUN);
    repeat (2) @(posedge clk);
    @(negedge clk);
    got = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble,
           bus.mul_start, bus.mul_busy};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      $display("FAIL reset_outputs: got %b expected %b", got, e);
      n_fail++;
    end
    n_checks++;
    if (bus.dbg_state !== IDLE || bus.dbg_mul_cnt !== 4'd0) begin
      $display("FAIL reset_state: got state %0d cnt %0d expected 0 0",
               bus.dbg_state, bus.dbg_mul_cnt);
      n_fail++;
    end
    n_checks++;
    if (bus.stall_cycles !== 32'd0 || bus.flush_count !== 32'd0) begin
      $display("FAIL reset_counters: got %0d %0d expected 0 0",
               bus.stall_cycles, bus.flush_count);
      n_fail++;
    end
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
    reset = 1'b1;
    exp_stall = 0;
    exp_flush = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_use();
    vec_t tbl[$];
    int r;
    logic u;
    tbl.push_back(mk(1,  2, 0, 1, 0, 0, 0, 1,  2, 1, 0, 0, E_STALL));
    tbl.push_back(mk(1,  2, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, E_RUN));
    tbl.push_back(mk(1, 31, 0, 1, 0, 0, 0, 1, 31, 1, 0, 0, E_RUN));
    tbl.push_back(mk(1,  3, 7, 0, 1, 0, 0, 1,  7, 1, 0, 0, E_STALL));
    tbl.push_back(mk(1,  3, 7, 0, 1, 0, 0, 0,  7, 1, 0, 0, E_RUN));
    tbl.push_back(mk(1,  5, 0, 0, 0, 0, 0, 1,  5, 1, 0, 0, E_RUN));
    tbl.push_back(mk(1,  5, 0, 1, 0, 0, 0, 1,  5, 0, 0, 0, E_RUN));
    tbl.push_back(mk(1,  6, 0, 1, 0, 0, 0, 1,  9, 1, 0, 0, E_RUN));
    for (int k = 0; k < 6; k++) begin
      r = $urandom_range(0, 30);
      u = 1'($urandom_range(0, 1));
      tbl.push_back(mk(1, 5'(r), 0, u, 0, 0, 0, 1, 5'(r), 1, 0, 0,
                       u ? E_STALL : E_RUN));
      tbl.push_back(mk(1, 5'(r), 0, u, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
    end
    foreach (tbl[i]) begin
      drive(tbl[i]);
      exp_q.push_back(tbl[i].exp);
      @(negedge clk);
      got = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble,
             bus.mul_start, bus.mul_busy};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        $display("FAIL load_use[%0d]: got %b expected %b", i, got, e);
        n_fail++;
      end
      @(posedge clk);
      if (!e[5]) exp_stall++;
      if (e[3])  exp_flush++;
      #1;
    end
  endtask

  task automatic test_flag_use();
    vec_t tbl[$];
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, E_STALL));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, E_RUN));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 4, 0, 0, 0, E_RUN));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, E_RUN));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, E_RUN));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      exp_q.push_back(tbl[i].exp);
      @(negedge clk);
      got = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble,
             bus.mul_start, bus.mul_busy};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        $display("FAIL flag_use[%0d]: got %b expected %b", i, got, e);
        n_fail++;
      end
      @(posedge clk);
      if (!e[5]) exp_stall++;
      if (e[3])  exp_flush++;
      #1;
    end
  endtask

  task automatic test_mul();
    vec_t tbl[$];
    tbl.push_back(mk(1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, E_START));
    tbl.push_back(mk(1, 3, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0, E_BUSY));
    // br_taken while busy is ignored
    tbl.push_back(mk(1, 3, 4, 1, 1, 0, 0, 0, 0, 0, 0, 1, E_BUSY));
    tbl.push_back(mk(1, 3, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0, E_RUN));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      exp_q.push_back(tbl[i].exp);
      @(negedge clk);
      got = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble,
             bus.mul_start, bus.mul_busy};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        $display("FAIL mul[%0d]: got %b expected %b", i, got, e);
        n_fail++;
      end
      n_checks++;
      if (bus.dbg_state !== ((i == 1 || i == 2) ? MUL_BUSY : IDLE)) begin
        $display("FAIL mul_state[%0d]: got %0d", i, bus.dbg_state);
        n_fail++;
      end
      @(posedge clk);
      if (!e[5]) exp_stall++;
      if (e[3])  exp_flush++;
      #1;
    end
`ifdef HAZARD_PERF_CNT_EN
    n_checks++;
    if (bus.stall_cycles !== 32'(exp_stall)) begin
      $display("FAIL mul_stall_cycles: got %0d expected %0d",
               bus.stall_cycles, exp_stall);
      n_fail++;
    end
`else
    n_checks++;
    if (bus.stall_cycles !== 32'd0) begin
      $display("FAIL mul_stall_cycles: got %0d expected 0", bus.stall_cycles);
      n_fail++;
    end
`endif
  endtask

  task automatic test_mul_load_use();
    vec_t tbl[$];
    tbl.push_back(mk(1, 2, 0, 1, 0, 1, 0, 1, 2, 1, 0, 0, E_STALL));
    tbl.push_back(mk(1, 2, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, E_START));
    tbl.push_back(mk(1, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_BUSY));
    tbl.push_back(mk(1, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_BUSY));
    tbl.push_back(mk(1, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      exp_q.push_back(tbl[i].exp);
      @(negedge clk);
      got = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble,
             bus.mul_start, bus.mul_busy};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        $display("FAIL mul_load_use[%0d]: got %b expected %b", i, got, e);
        n_fail++;
      end
      @(posedge clk);
      if (!e[5]) exp_stall++;
      if (e[3])  exp_flush++;
      #1;
    end
  endtask

  task automatic test_flush();
    vec_t tbl[$];
    tbl.push_back(mk(1, 2, 0, 1, 0, 0, 0, 1, 2, 1, 0, 1, E_FLUSH));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, E_FLUSH));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, E_FLUSH));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      exp_q.push_back(tbl[i].exp);
      @(negedge clk);
      got = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble,
             bus.mul_start, bus.mul_busy};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        $display("FAIL flush[%0d]: got %b expected %b", i, got, e);
        n_fail++;
      end
      @(posedge clk);
      if (!e[5]) exp_stall++;
      if (e[3])  exp_flush++;
      #1;
    end
`ifdef HAZARD_PERF_CNT_EN
    n_checks++;
    if (bus.flush_count !== 32'(exp_flush) ||
        bus.stall_cycles !== 32'(exp_stall)) begin
      $display("FAIL flush_counters: got %0d %0d expected %0d %0d",
               bus.flush_count, bus.stall_cycles, exp_flush, exp_stall);
      n_fail++;
    end
`else
    n_checks++;
    if (bus.flush_count !== 32'd0) begin
      $display("FAIL flush_counters: got %0d expected 0", bus.flush_count);
      n_fail++;
    end
`endif
  endtask

  task automatic test_reset_mid_mul();
    vec_t tbl[$];
    // issue a MUL and reach the first busy cycle
    drive(mk(1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, E_START));
    exp_q.push_back(E_START);
    @(negedge clk);
    got = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble,
           bus.mul_start, bus.mul_busy};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      $display("FAIL rst_mul_issue: got %b expected %b", got, e);
      n_fail++;
    end
    @(posedge clk);
    #1;
    drive(mk(1, 3, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0, E_BUSY));
    exp_q.push_back(E_BUSY);
    #2;
    got = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble,
           bus.mul_start, bus.mul_busy};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      $display("FAIL rst_mul_busy: got %b expected %b", got, e);
      n_fail++;
    end
    // asynchronous reset mid-busy, with hazardous inputs present
    drive(mk(1, 2, 0, 1, 0, 1, 1, 1, 2, 1, 1, 1, E_RUN));
    reset = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    exp_q.push_back(E_RUN);
    #1;
    got = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble,
           bus.mul_start, bus.mul_busy};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      $display("FAIL rst_mul_outputs: got %b expected %b", got, e);
      n_fail++;
    end
    n_checks++;
    if (bus.dbg_state !== IDLE || bus.stall_cycles !== 32'd0 ||
        bus.flush_count !== 32'd0) begin
      $display("FAIL rst_mul_state: got state %0d stall %0d flush %0d",
               bus.dbg_state, bus.stall_cycles, bus.flush_count);
      n_fail++;
    end
    #3;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
    reset = 1'b1;
    @(posedge clk);
    #1;
    // a fresh MUL after reset runs its full sequence
    tbl.push_back(mk(1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, E_START));
    tbl.push_back(mk(1, 3, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0, E_BUSY));
    tbl.push_back(mk(1, 3, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0, E_BUSY));
    tbl.push_back(mk(1, 3, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0, E_RUN));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      exp_q.push_back(tbl[i].exp);
      @(negedge clk);
      got = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble,
             bus.mul_start, bus.mul_busy};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        $display("FAIL rst_mul_reissue[%0d]: got %b expected %b", i, got, e);
        n_fail++;
      end
      @(posedge clk);
      if (!e[5]) exp_stall++;
      if (e[3])  exp_flush++;
      #1;
    end
`ifdef HAZARD_PERF_CNT_EN
    n_checks++;
    if (bus.stall_cycles !== 32'(exp_stall)) begin
      $display("FAIL rst_mul_stall_cycles: got %0d expected %0d",
               bus.stall_cycles, exp_stall);
      n_fail++;
    end
`endif
  endtask

  task automatic test_back_to_back();
    vec_t tbl[$];
    tbl.push_back(mk(1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, E_START));
    tbl.push_back(mk(1, 3, 4, 1, 1, 1, 0, 0, 0, 0, 0, 0, E_START));
    tbl.push_back(mk(1, 5, 6, 1, 1, 1, 0, 0, 0, 0, 0, 0, E_START));
    tbl.push_back(mk(1, 5, 6, 1, 1, 0, 0, 0, 0, 0, 0, 0, E_RUN));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      exp_q.push_back(tbl[i].exp);
      @(negedge clk);
      got = {bus1.pc_en, bus1.ifid_en, bus1.ifid_flush, bus1.idex_bubble,
             bus1.mul_start, bus1.mul_busy};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        $display("FAIL back_to_back[%0d]: got %b expected %b", i, got, e);
        n_fail++;
      end
      n_checks++;
      if (bus1.dbg_state !== IDLE) begin
        $display("FAIL back_to_back_state[%0d]: got %0d expected 0",
                 i, bus1.dbg_state);
        n_fail++;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_stall = 0;
    exp_flush = 0;
    test_reset();
    test_load_use();
    test_flag_use();
    test_mul();
    test_mul_load_use();
    test_flush();
    test_reset_mid_mul();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
      n_fail++;
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  // Overall time guard so the run always ends with a summary.
  initial begin
    #50000;
    n_fail++;
    $display("FAIL timeout: got no completion expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_pipe_hazard_ctrl

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage ARMv8 core, sitting beside the ID-stage control decoder. It inspects decoded ID-stage fields and EX-stage state, and drives PC/IF-ID enables, IF-ID flush and ID-EX bubble insertion. It covers load-use, flag-use (B.LT after ADDS/SUBS) and taken-branch hazards. It also sequences the multi-cycle MUL unit through a start/busy handshake.

Parameters:
MUL_LAT, 3, total EX-stage cycles a MUL occupies (legal range 1..15)
CNT_W, 32, width of the optional performance counters

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous reset, active-low
id_valid  input  1  ID stage holds a real instruction
id_rn  input  5  ID source register Rn
id_rm  input  5  ID second source register (post Reg2Loc mux)
id_uses_rn  input  1  ID instruction reads Rn
id_uses_rm  input  1  ID instruction reads the second source
id_is_mul  input  1  ID instruction is MUL
id_is_blt  input  1  ID instruction is B.LT
ex_valid  input  1  EX stage holds a real instruction
ex_rd  input  5  EX destination register
ex_mem_read  input  1  EX instruction is LDUR
ex_set_flags  input  1  EX instruction sets NZCV
br_taken  input  1  branch resolved taken this cycle (from EX)
pc_en  output  1  PC update enable
ifid_en  output  1  IF/ID register load enable
ifid_flush  output  1  zero IF/ID on next edge
idex_bubble  output  1  load a NOP into ID/EX on next edge
mul_start  output  1  one-cycle pulse; MUL enters EX
mul_busy  output  1  MUL sequencer active
stall_cycles  output  CNT_W  optional; see below
flush_count  output  CNT_W  optional; see below

Behaviour:
- Registered state: FSM {IDLE, MUL_BUSY} and a 4-bit down-counter mul_cnt. All enables and strobes are combinational from state plus inputs.
- Reset (reset=0, asynchronous): state=IDLE, mul_cnt=0, counters=0.
- Outputs while reset is held: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0, mul_start=0, mul_busy=0.
- Hazard definitions:
  - load_use = ex_valid & ex_mem_read & ex_rd!=31 & ((id_uses_rn & id_rn==ex_rd) | (id_uses_rm & id_rm==ex_rd)). X31 never hazards.
  - flag_use = id_valid & id_is_blt & ex_valid & ex_set_flags.
- Priority, highest first, evaluated each cycle:
  1. IDLE & br_taken: ifid_flush=1, idex_bubble=1, pc_en=1, ifid_en=1. All other hazards are suppressed, because the ID instruction is wrong-path. mul_start=0.
  2. MUL_BUSY: pc_en=0, ifid_en=0, idex_bubble=0, mul_busy=1. EX is held by the MUL unit. mul_cnt decrements each cycle; when mul_cnt==1, the next state is IDLE. br_taken in MUL_BUSY is a protocol violation (the branch is younger than the MUL) and is ignored.
  3. IDLE & (load_use | flag_use): pc_en=0, ifid_en=0, idex_bubble=1 for exactly 1 cycle. The stall drops naturally once the bubble reaches EX.
  4. IDLE & id_valid & id_is_mul: mul_start=1 and the front end advances normally this cycle (the MUL moves to EX).
     - If MUL_LAT>1: next state is MUL_BUSY with mul_cnt=MUL_LAT-1.
     - If MUL_LAT==1: remain in IDLE.
  5. Otherwise: all enables high, no bubble, no flush.
- Latency: a MUL stalls the front end for MUL_LAT-1 cycles after mul_start. A load-use or flag-use hazard stalls for 1 cycle. A flush costs 1 bubble plus 1 flushed fetch.
- A MUL with its own load-use hazard takes the 1-cycle stall first and issues on the following cycle.
- Reset asserted mid-MUL_BUSY returns the FSM to IDLE immediately; the MUL unit is reset by the same signal.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: stall_cycles increments every cycle with pc_en=0; flush_count increments every cycle with ifid_flush=1. Both saturate at all-ones and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops exist.

Decomposition:
- Shared package cpu_pkg holds:
  - hazard_state_t enum {IDLE, MUL_BUSY}
  - localparam XZR=5'd31
  - opcode-field width constants shared with cpu_cntrl
- One natural sub-module: hazard_perf_cnt (a saturating counter, instantiated twice under the macro).

Test Plan:
- LDUR X2 in EX (ex_rd=2) with ADDS reading rn=2 in ID -> one cycle of pc_en=0, ifid_en=0, idex_bubble=1, then normal flow. Repeat with ex_rd=31 -> no stall.
- SUBS in EX (ex_set_flags=1) with B.LT in ID -> 1-cycle stall. With ADDI in EX instead -> no stall.
- MUL in ID, MUL_LAT=3 -> mul_start pulse in cycle 0; mul_busy=1 and pc_en=0 in cycles 1-2; IDLE in cycle 3; stall_cycles=2.
- br_taken=1 together with load_use=1 -> ifid_flush=1, idex_bubble=1, pc_en=1; no stall; flush_count=1.
- reset driven low during cycle 1 of MUL_BUSY -> immediate IDLE with all outputs at reset values; after reset is released, a new MUL issues normally.
- MUL_LAT=1 back-to-back MULs in ID -> mul_start high on consecutive cycles, mul_busy never asserted.
